// File: rtl/sd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// FSM states and reverse double-dabble correction constants.
package sd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] CORR_THR = 4'd8;
   localparam logic [3:0] CORR_SUB = 4'd3;

   function automatic logic nib_bad(input logic [3:0] n);
      return n > 4'd9;
   endfunction

endpackage

// File: rtl/bcd_nib_corr.sv
// One BCD nibble correction step for reverse double-dabble.
// Subtracts the correction constant when the nibble reaches the threshold.
module bcd_nib_corr
   import sd_pkg::*;
(
   input  logic [3:0] nib,
   output logic [3:0] q
);

   assign q = (nib >= CORR_THR) ? nib - CORR_SUB : nib;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Define BCD_CHECK_EN to reject inputs holding a nibble above 9.
module bcd_to_bin
   import sd_pkg::*;
#(
   parameter int N_DIGITS = 2,
   parameter int BIN_W    = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int SR_W  = 4*N_DIGITS + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   state_t            st, st_nx;
   logic [SR_W-1:0]   sr, sr_sh, sr_nx;
   logic [CNT_W-1:0]  cnt;
   logic              armed;
   logic              load, last, bad;

   assign sr_sh = sr >> 1;
   assign sr_nx[BIN_W-1:0] = sr_sh[BIN_W-1:0];

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_corr
      bcd_nib_corr u_corr (
         .nib (sr_sh[BIN_W+4*g +: 4]),
         .q   (sr_nx[BIN_W+4*g +: 4])
      );
   end

   // First edge after reset is never a load edge.
   assign load = (st == IDLE) && start && armed;
   assign last = (cnt == CNT_W'(BIN_W - 1));
   assign busy = (st == SHIFT);
   assign done = (st == DONE);

`ifdef BCD_CHECK_EN
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < N_DIGITS; i++)
         if (nib_bad(bcd_in[4*i +: 4])) bad = 1'b1;
   end
`else
   assign bad = 1'b0;
`endif

   always_comb begin
      st_nx = st;
      unique case (st)
         IDLE:    if (load) st_nx = bad ? DONE : SHIFT;
         SHIFT:   if (last) st_nx = DONE;
         DONE:    st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         cnt     <= '0;
         bin_out <= '0;
         armed   <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (load) begin
            sr  <= {bcd_in, {BIN_W{1'b0}}};
            cnt <= '0;
            if (bad) bin_out <= '0;
         end else if (st == SHIFT) begin
            sr  <= sr_nx;
            cnt <= cnt + CNT_W'(1);
            if (last) bin_out <= sr_nx[BIN_W-1:0];
         end
      end
   end

`ifdef BCD_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (load && bad)
         err_q <= 1'b1;
      else if (st == SHIFT && last)
         err_q <= 1'b0;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: arithmetic reference model,
// expectations queued at the load edge, checked by a done monitor.
module tb_bcd_to_bin;

   localparam int ND = 2;
   localparam int BW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [4*ND-1:0] bcd_in = '0;
   logic [BW-1:0] bin_out;
   logic          busy, done, err;

   typedef struct {
      logic [BW-1:0] bin;
      logic          e;
      int            lat;
   } exp_t;

   exp_t q[$];
   exp_t ex_m;
   int   dq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ndone = 0;
   int   last_done_cyc = 0;

   bcd_to_bin #(.N_DIGITS(ND), .BIN_W(BW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bcd_in  (bcd_in),
      .bin_out (bin_out),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t ref_model(input logic [4*ND-1:0] b);
      exp_t r;
      int   v;
      bit   bad;
      v = 0;
      bad = 0;
      for (int i = ND - 1; i >= 0; i--) begin
         int d;
         d = int'(b[4*i +: 4]);
         if (d > 9) bad = 1;
         v = v * 10 + d;
      end
      r.bin = v[BW-1:0];
      r.e   = 1'b0;
      r.lat = BW + 1;
`ifdef BCD_CHECK_EN
      if (bad) begin
         r.bin = '0;
         r.e   = 1'b1;
         r.lat = 1;
      end
`endif
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         ndone++;
         last_done_cyc = cyc;
         dq.push_back(cyc);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 bin=%0d",
                     bin_out);
         end else begin
            ex_m = q.pop_front();
            chk("bin_out", 32'(bin_out), 32'(ex_m.bin));
            chk("err", 32'(err), 32'(ex_m.e));
         end
      end
   end

   task automatic wait_done(input int n0, input int s, input int lat,
                            input logic ebusy);
      bit got;
      got = 0;
      #1;
      chk("busy_after_load", 32'(busy), 32'(ebusy));
      for (int k = 0; k < 40; k++) begin
         if (ndone > n0) begin
            got = 1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=0 required=1");
      end else begin
         chk("latency", 32'(last_done_cyc - s + 1), 32'(lat));
         chk("busy_in_done", 32'(busy), 32'd0);
      end
   endtask

   task automatic issue(input logic [4*ND-1:0] b);
      exp_t e;
      int   n0, s;
      e = ref_model(b);
      @(negedge clk);
      bcd_in = b;
      start = 1'b1;
      n0 = ndone;
      @(posedge clk);
      q.push_back(e);
      @(negedge clk);
      s = cyc;
      start = 1'b0;
      wait_done(n0, s, e.lat, e.lat != 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int n0, s;
      logic [4*ND-1:0] b;

      // reset with start already high
      start = 1'b1;
      bcd_in = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_bin_out", 32'(bin_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_edge_ignored", 32'(busy), 32'd0);
      n0 = ndone;
      @(posedge clk);
      q.push_back(ref_model(8'h00));
      @(negedge clk);
      s = cyc;
      start = 1'b0;
      wait_done(n0, s, BW + 1, 1'b1);

      issue(8'h99);
      issue(8'h30);
      issue(8'h15);

      // restart and input change during a conversion are ignored
      @(negedge clk);
      bcd_in = 8'h27;
      start = 1'b1;
      n0 = ndone;
      @(posedge clk);
      q.push_back(ref_model(8'h27));
      @(negedge clk);
      s = cyc;
      start = 1'b0;
      repeat (2) @(negedge clk);
      bcd_in = 8'h42;
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done(n0, s, BW + 1, 1'b1);
      n0 = ndone;
      repeat (12) @(negedge clk);
      chk("single_done", 32'(ndone - n0), 32'd0);

      // abort by reset at iteration 4
      @(negedge clk);
      bcd_in = 8'h56;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("abort_bin_out", 32'(bin_out), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n0 = ndone;
      repeat (12) @(negedge clk);
      chk("abort_no_done", 32'(ndone - n0), 32'd0);
      issue(8'h56);

`ifdef BCD_CHECK_EN
      issue(8'h1A);
      issue(8'h12);
`endif

      // random valid conversions
      for (int i = 0; i < 20; i++) begin
         b = '0;
         for (int d = 0; d < ND; d++)
            b[4*d +: 4] = 4'($urandom_range(0, 9));
         issue(b);
      end
`ifdef BCD_CHECK_EN
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom_range(0, 255));
         b[4*(i%ND) +: 4] = 4'($urandom_range(10, 15));
         issue(b);
      end
`endif

      // start held high: one conversion per BW+2 cycles
      @(negedge clk);
      dq.delete();
      n0 = ndone;
      bcd_in = 8'h07;
      start = 1'b1;
      for (int j = 0; j < 30; j++) begin
         @(posedge clk);
         if (j % (BW + 2) == 0) q.push_back(ref_model(8'h07));
      end
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #1;
      chk("hold_done_count", 32'(ndone - n0), 32'd4);
      for (int k = 1; k < dq.size(); k++)
         chk("hold_period", 32'(dq[k] - dq[k-1]), 32'(BW + 2));
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
